trace_request_engine: RTL and testbench
=======================================

Name: trace_request_engine

Overview:
- Initiator side of the trace repository request/mark-done protocol.
- Requests the next executable trace entry and claims it by marking it processing.
- Hands the entry to a downstream executor over a valid/ready handshake, then retires it once the executor reports completion.
- Cancels requests that stall too long, backs off, and stops when the repository reports processing complete. One entry in flight at a time.

Parameters:
- TRACE_ENTRIES, 2048, repository depth; index width is $clog2(TRACE_ENTRIES).
- WAIT_TIMEOUT, 64, REQ cycles before cancel is raised; 0 means never cancel.
- BACKOFF_CYCLES, 8, idle cycles after a cancel before re-requesting (minimum 1).
- COUNT_WIDTH, 16, width of the statistics counters.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; one clock, asynchronous, active-low
- enable  in  1  run request loop
- trace_req  out  1  request next entry
- cancel  out  1  abandon pending request
- trace_in  in  trace_format  entry from repository
- trace_index_i  in  IDXW  index of delivered entry
- entry_valid  in  1  entry delivered
- cancelled  in  1  cancel acknowledged
- processing_complete  in  1  no unserved entries remain
- index_done  out  IDXW  index being marked
- mark_done  out  1  mark request
- processing_flag  out  1  1 = claim (processing), 0 = retire
- mark_done_valid  in  1  mark acknowledged
- exec_valid  out  1  entry offered to executor
- exec_ready  in  1  executor accepts
- exec_entry  out  trace_format  offered entry
- exec_index  out  IDXW  offered index
- exec_done  in  1  executor finished current entry (single-cycle pulse)
- done  out  1  repository exhausted
- busy  out  1  entry in flight (CLAIM..RETIRE)
- dispatch_count  out  COUNT_WIDTH  entries retired
- cancel_count  out  COUNT_WIDTH  cancels acknowledged

Behaviour:
- Reset: every output 0, all counters 0, state IDLE, latched entry/index cleared. Reset is taken mid-operation with no handshake completion. A claimed-but-unretired entry stays "processing" in the repository; this is an accepted limitation.
- IDLE: if enable=1, go to REQ next cycle.
- REQ: trace_req=1. The wait counter increments each cycle.
  - If WAIT_TIMEOUT≠0 and the counter reaches WAIT_TIMEOUT, cancel=1 is held with trace_req.
  - Priority when several inputs are high on the same edge: entry_valid > cancelled > processing_complete.
  - entry_valid: latch trace_in and trace_index_i, drop trace_req/cancel, go to CLAIM.
  - cancelled: drop both, increment cancel_count, go to BACKOFF.
  - processing_complete: drop trace_req, go to DONE.
  - enable is ignored in REQ.
- CLAIM: mark_done=1, processing_flag=1, index_done=latched index. Held until mark_done_valid is sampled high, deasserted on that edge, then go to ISSUE.
- ISSUE: exec_valid=1; exec_entry and exec_index are stable. On exec_valid&&exec_ready, drop exec_valid and go to EXEC.
- EXEC: wait for exec_done. exec_done arriving on the ISSUE handshake edge is recorded and honoured; EXEC then exits on the next cycle. On exec_done, go to RETIRE.
- RETIRE: mark_done=1, processing_flag=0, same index, held until mark_done_valid. Then increment dispatch_count and go to REQ if enable=1, else IDLE.
- BACKOFF: trace_req=0 for BACKOFF_CYCLES cycles, then go to REQ if enable=1, else IDLE.
- DONE: done=1 until enable is sampled 0, then go to IDLE.
- trace_req is always low for at least one cycle between successive requests, because it is low throughout CLAIM..RETIRE and BACKOFF.
- busy=1 in CLAIM, ISSUE, EXEC and RETIRE.
- Counters saturate at all-ones and never wrap. The wait counter clears on REQ entry.
- Stray inputs (entry_valid, mark_done_valid, exec_ready or exec_done) outside their consuming state are ignored.

Decomposition:
- trace_format is taken from trace_repository_datatypes.
- Add to that package: the state enum trace_req_state_e, and the processing_flag encodings PF_CLAIM=1 and PF_RETIRE=0.
- Sub-module: sat_counter (parameter WIDTH; inc, clr, q), instantiated for dispatch_count and cancel_count.
- The FSM stays in the top level.

Test Plan:
- Single entry, executor ready: repository answers entry_valid at index 5, mark_done_valid 1 cycle after each mark, exec_ready tied 1, exec_done 3 cycles later → claim mark (idx 5, flag 1), exec_valid for 1 cycle, retire mark (idx 5, flag 0), dispatch_count=1, trace_req reasserts afterwards.
- Timeout and cancel: WAIT_TIMEOUT=4, no entry_valid → cancel rises on the 5th REQ cycle; cancelled 2 cycles later → trace_req low for 8 cycles, cancel_count=1, then REQ again.
- Exhaustion: processing_complete=1 during REQ → done=1, trace_req=0; drop enable → IDLE with done=0.
- Executor backpressure: exec_ready low for 10 cycles → exec_valid held with exec_entry/exec_index unchanged, no retire until exec_done.
- Simultaneous events: entry_valid and cancelled on the same edge → entry accepted, cancel_count unchanged; exec_done on the exec_ready edge → retire follows without hang.
- Async reset asserted in EXEC (mid-cycle) → all outputs 0 immediately, counters 0; after release with enable=1, REQ resumes.

Source files
------------

// File: rtl/trace_repository_datatypes.sv
// Shared types for the trace repository protocol and its request engine.
// Entry format, engine state encoding and mark-done flag values.
package trace_repository_datatypes;

  typedef struct packed {
    logic [7:0]  op;
    logic [23:0] addr;
  } trace_format;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_CLAIM,
    S_ISSUE,
    S_EXEC,
    S_RETIRE,
    S_BACKOFF,
    S_DONE
  } trace_req_state_e;

  localparam logic PF_CLAIM  = 1'b1;
  localparam logic PF_RETIRE = 1'b0;

endpackage

// File: rtl/trace_request_engine_if.sv
// Repository request/mark-done and executor handshake bundle.
// master = request engine, slave = repository plus executor.
interface trace_request_engine_if #(
  parameter int IDXW = 11
);
  import trace_repository_datatypes::*;

  logic            trace_req;
  logic            cancel;
  trace_format     trace_in;
  logic [IDXW-1:0] trace_index_i;
  logic            entry_valid;
  logic            cancelled;
  logic            processing_complete;
  logic [IDXW-1:0] index_done;
  logic            mark_done;
  logic            processing_flag;
  logic            mark_done_valid;
  logic            exec_valid;
  logic            exec_ready;
  trace_format     exec_entry;
  logic [IDXW-1:0] exec_index;
  logic            exec_done;

  modport master (
    output trace_req, cancel,
    output index_done, mark_done,
    output processing_flag,
    output exec_valid, exec_entry,
    output exec_index,
    input  trace_in, trace_index_i,
    input  entry_valid, cancelled,
    input  processing_complete,
    input  mark_done_valid,
    input  exec_ready, exec_done
  );

  modport slave (
    input  trace_req, cancel,
    input  index_done, mark_done,
    input  processing_flag,
    input  exec_valid, exec_entry,
    input  exec_index,
    output trace_in, trace_index_i,
    output entry_valid, cancelled,
    output processing_complete,
    output mark_done_valid,
    output exec_ready, exec_done
  );

endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
// Holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != '1)) begin
      cnt_d = cnt_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign q = cnt_q;

endmodule

// File: rtl/trace_request_engine.sv
// Initiator for the trace repository: request, claim, execute, retire.
// One entry in flight; stalled requests are cancelled and backed off.
module trace_request_engine
  import trace_repository_datatypes::*;
#(
  parameter int TRACE_ENTRIES  = 2048,
  parameter int WAIT_TIMEOUT   = 64,
  parameter int BACKOFF_CYCLES = 8,
  parameter int COUNT_WIDTH    = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   enable,
  trace_request_engine_if.master bus,
  output logic                   done,
  output logic                   busy,
  output logic [COUNT_WIDTH-1:0] dispatch_count,
  output logic [COUNT_WIDTH-1:0] cancel_count
);

  localparam int IDXW = $clog2(TRACE_ENTRIES);
  localparam int WTW  = (WAIT_TIMEOUT > 0) ?
                        $clog2(WAIT_TIMEOUT + 1) : 1;
  localparam int BOC  = (BACKOFF_CYCLES < 1) ?
                        1 : BACKOFF_CYCLES;
  localparam int BOW  = $clog2(BOC + 1);

  localparam logic [WTW-1:0] WT_MAX  = WTW'(WAIT_TIMEOUT);
  localparam logic [BOW-1:0] BO_LAST = BOW'(BOC - 1);

  trace_req_state_e state_q, state_d;
  logic [WTW-1:0]   wait_q, wait_d;
  logic [BOW-1:0]   bo_q, bo_d;
  trace_format      entry_q, entry_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic             early_q, early_d;

  logic req_o, cancel_o, mark_o, flag_o;
  logic xvalid_o, done_o, busy_o;
  logic disp_inc, canc_inc, to_hit;

  assign to_hit = (WAIT_TIMEOUT != 0) && (wait_q == WT_MAX);

  always_comb begin
    state_d  = state_q;
    wait_d   = '0;
    bo_d     = '0;
    entry_d  = entry_q;
    idx_d    = idx_q;
    early_d  = 1'b0;
    req_o    = 1'b0;
    cancel_o = 1'b0;
    mark_o   = 1'b0;
    flag_o   = PF_RETIRE;
    xvalid_o = 1'b0;
    done_o   = 1'b0;
    busy_o   = 1'b0;
    disp_inc = 1'b0;
    canc_inc = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (enable) state_d = S_REQ;
      end
      S_REQ: begin
        req_o    = 1'b1;
        cancel_o = to_hit;
        // counter parks at the limit so cancel stays held
        wait_d   = to_hit ? wait_q : wait_q + WTW'(1);
        if (bus.entry_valid) begin
          entry_d = bus.trace_in;
          idx_d   = bus.trace_index_i;
          state_d = S_CLAIM;
        end else if (bus.cancelled) begin
          canc_inc = 1'b1;
          state_d  = S_BACKOFF;
        end else if (bus.processing_complete) begin
          state_d = S_DONE;
        end
      end
      S_CLAIM: begin
        busy_o = 1'b1;
        mark_o = 1'b1;
        flag_o = PF_CLAIM;
        if (bus.mark_done_valid) state_d = S_ISSUE;
      end
      S_ISSUE: begin
        busy_o   = 1'b1;
        xvalid_o = 1'b1;
        if (bus.exec_ready) begin
          early_d = bus.exec_done;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        busy_o = 1'b1;
        if (bus.exec_done || early_q) state_d = S_RETIRE;
      end
      S_RETIRE: begin
        busy_o = 1'b1;
        mark_o = 1'b1;
        flag_o = PF_RETIRE;
        if (bus.mark_done_valid) begin
          disp_inc = 1'b1;
          state_d  = enable ? S_REQ : S_IDLE;
        end
      end
      S_BACKOFF: begin
        if (bo_q == BO_LAST) state_d = enable ? S_REQ : S_IDLE;
        else                 bo_d    = bo_q + BOW'(1);
      end
      S_DONE: begin
        done_o = 1'b1;
        if (!enable) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      wait_q  <= '0;
      bo_q    <= '0;
      entry_q <= '0;
      idx_q   <= '0;
      early_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      bo_q    <= bo_d;
      entry_q <= entry_d;
      idx_q   <= idx_d;
      early_q <= early_d;
    end
  end

  sat_counter #(.WIDTH(COUNT_WIDTH)) u_disp (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (disp_inc),
    .clr   (1'b0),
    .q     (dispatch_count)
  );

  sat_counter #(.WIDTH(COUNT_WIDTH)) u_canc (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (canc_inc),
    .clr   (1'b0),
    .q     (cancel_count)
  );

  assign bus.trace_req       = req_o;
  assign bus.cancel          = cancel_o;
  assign bus.mark_done       = mark_o;
  assign bus.processing_flag = flag_o;
  assign bus.index_done      = idx_q;
  assign bus.exec_valid      = xvalid_o;
  assign bus.exec_entry      = entry_q;
  assign bus.exec_index      = idx_q;
  assign done                = done_o;
  assign busy                = busy_o;

endmodule

// File: tb/tb_trace_request_engine.sv
// Scoreboard bench for trace_request_engine.
// Repository/executor models answer the engine; monitor checks order.
module tb_trace_request_engine;
  import trace_repository_datatypes::*;

  localparam int K_CLAIM  = 0;
  localparam int K_EXEC   = 1;
  localparam int K_RETIRE = 2;

  typedef struct {
    int          kind;
    logic [10:0] idx;
    trace_format ent;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic        done;
  logic        busy;
  logic [15:0] dispatch_count;
  logic [15:0] cancel_count;

  int n_tests = 0;
  int n_fail  = 0;
  int done_delay = 3;
  ev_t sb_q[$];

  trace_request_engine_if #(.IDXW(11)) bus ();

  trace_request_engine #(
    .TRACE_ENTRIES  (2048),
    .WAIT_TIMEOUT   (4),
    .BACKOFF_CYCLES (8),
    .COUNT_WIDTH    (16)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .enable         (enable),
    .bus            (bus.master),
    .done           (done),
    .busy           (busy),
    .dispatch_count (dispatch_count),
    .cancel_count   (cancel_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic sig(input int sel,
                               input int arg);
    case (sel)
      0: return bus.trace_req;
      1: return bus.exec_valid;
      2: return busy && !bus.exec_valid &&
                !bus.mark_done;
      default: return dispatch_count == 16'(arg);
    endcase
  endfunction

  task automatic wait_until(input string tag,
                            input int sel,
                            input int arg,
                            input int budget);
    int n = 0;
    while (!sig(sel, arg) && n < budget) begin
      tick();
      n++;
    end
    chk(tag, 64'(sig(sel, arg)), 64'd1);
  endtask

  task automatic offer(input logic [10:0] idx,
                       input trace_format e,
                       input bit with_retire);
    ev_t ev;
    ev.idx  = idx;
    ev.ent  = e;
    ev.kind = K_CLAIM;
    sb_q.push_back(ev);
    ev.kind = K_EXEC;
    sb_q.push_back(ev);
    if (with_retire) begin
      ev.kind = K_RETIRE;
      sb_q.push_back(ev);
    end
    bus.entry_valid   = 1'b1;
    bus.trace_in      = e;
    bus.trace_index_i = idx;
  endtask

  task automatic sb_pop(input int kind,
                        input logic [10:0] idx,
                        input trace_format e);
    ev_t ev;
    if (sb_q.size() == 0) begin
      chk("sb_underflow", 64'd1, 64'd0);
    end else begin
      ev = sb_q.pop_front();
      chk("sb_kind", 64'(kind), 64'(ev.kind));
      chk("sb_idx", 64'(idx), 64'(ev.idx));
      if (kind == K_EXEC)
        chk("sb_entry", 64'(e), 64'(ev.ent));
    end
  endtask

  // handshakes complete on the next rising edge
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.mark_done && bus.mark_done_valid)
        sb_pop(bus.processing_flag ? K_CLAIM : K_RETIRE,
               bus.index_done, '0);
      if (bus.exec_valid && bus.exec_ready)
        sb_pop(K_EXEC, bus.exec_index, bus.exec_entry);
    end
  end

  initial begin
    bus.mark_done_valid = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      bus.mark_done_valid = rst_n && bus.mark_done &&
                            !bus.mark_done_valid;
    end
  end

  initial begin
    int pend = 0;
    bus.exec_done = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      bus.exec_done = 1'b0;
      if (!rst_n) begin
        pend = 0;
      end else begin
        if (pend > 0) begin
          pend--;
          if (pend == 0) bus.exec_done = 1'b1;
        end
        if (bus.exec_valid && bus.exec_ready) begin
          if (done_delay == 0) bus.exec_done = 1'b1;
          else                 pend = done_delay;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    trace_format e1, e2, e3, e4;
    bit hold_ok;
    int n;
    e1 = trace_format'{8'h11, 24'h000ABC};
    e2 = trace_format'{8'h22, 24'h123456};
    e3 = trace_format'{8'h33, 24'hFEDCBA};
    e4 = trace_format'{8'h44, 24'h00F00D};
    rst_n   = 1'b0;
    enable  = 1'b0;
    bus.trace_in            = '0;
    bus.trace_index_i       = '0;
    bus.entry_valid         = 1'b0;
    bus.cancelled           = 1'b0;
    bus.processing_complete = 1'b0;
    bus.exec_ready          = 1'b0;
    repeat (3) tick();
    chk("rst_req", 64'(bus.trace_req), 64'd0);
    chk("rst_mark", 64'(bus.mark_done), 64'd0);
    chk("rst_xvalid", 64'(bus.exec_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_disp", 64'(dispatch_count), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // single entry, executor always ready
    tick();
    enable = 1'b1;
    bus.exec_ready = 1'b1;
    done_delay = 3;
    wait_until("t1_req", 0, 0, 10);
    offer(11'd5, e1, 1'b1);
    tick();
    bus.entry_valid = 1'b0;
    wait_until("t1_disp", 3, 1, 40);
    chk("t1_req_again", 64'(bus.trace_req), 64'd1);

    // timeout, cancel, backoff
    chk("t2_c1", 64'(bus.cancel), 64'd0);
    repeat (3) tick();
    chk("t2_c4", 64'(bus.cancel), 64'd0);
    tick();
    chk("t2_c5", 64'(bus.cancel), 64'd1);
    chk("t2_req5", 64'(bus.trace_req), 64'd1);
    repeat (2) tick();
    bus.cancelled = 1'b1;
    tick();
    bus.cancelled = 1'b0;
    chk("t2_ccnt", 64'(cancel_count), 64'd1);
    n = 0;
    while (!bus.trace_req && n < 20) begin
      n++;
      tick();
    end
    chk("t2_backoff", 64'(n), 64'd8);

    // entry and cancel ack on one edge; early exec_done
    done_delay = 0;
    offer(11'd9, e2, 1'b1);
    bus.cancelled = 1'b1;
    tick();
    bus.entry_valid = 1'b0;
    bus.cancelled   = 1'b0;
    wait_until("t3_disp", 3, 2, 40);
    chk("t3_ccnt", 64'(cancel_count), 64'd1);

    // executor backpressure
    done_delay = 3;
    bus.exec_ready = 1'b0;
    wait_until("t4_req", 0, 0, 10);
    offer(11'd77, e3, 1'b1);
    tick();
    bus.entry_valid = 1'b0;
    wait_until("t4_valid", 1, 0, 10);
    hold_ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (!bus.exec_valid || bus.mark_done ||
          bus.exec_entry != e3 ||
          bus.exec_index != 11'd77)
        hold_ok = 1'b0;
      tick();
    end
    chk("t4_hold", 64'(hold_ok), 64'd1);
    chk("t4_entry", 64'(bus.exec_entry), 64'(e3));
    chk("t4_nodisp", 64'(dispatch_count), 64'd2);
    bus.exec_ready = 1'b1;
    wait_until("t4_disp", 3, 3, 40);

    // exhaustion
    bus.processing_complete = 1'b1;
    tick();
    bus.processing_complete = 1'b0;
    chk("t5_done", 64'(done), 64'd1);
    chk("t5_req", 64'(bus.trace_req), 64'd0);
    tick();
    chk("t5_hold", 64'(done), 64'd1);
    enable = 1'b0;
    tick();
    chk("t5_idle", 64'(done), 64'd0);
    tick();
    chk("t5_noreq", 64'(bus.trace_req), 64'd0);

    // async reset while executing
    enable = 1'b1;
    done_delay = 20;
    wait_until("t6_req", 0, 0, 10);
    offer(11'd3, e4, 1'b0);
    tick();
    bus.entry_valid = 1'b0;
    wait_until("t6_exec", 2, 0, 20);
    chk("t6_sb", 64'(sb_q.size()), 64'd0);
    #3;
    rst_n = 1'b0;
    #1;
    chk("t6_busy", 64'(busy), 64'd0);
    chk("t6_idx", 64'(bus.exec_index), 64'd0);
    chk("t6_disp", 64'(dispatch_count), 64'd0);
    chk("t6_canc", 64'(cancel_count), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_until("t6_resume", 0, 0, 10);
    chk("end_sb", 64'(sb_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
